mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Wait-state memory responder: word reads, word/half/byte stores with
// alignment checks, programmable wait cycles before each access.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_OE,
  input  logic        MEM_WS,
  input  logic [1:0]  RAM_SEL,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        MEM_READY,
  output logic        MEM_BUSY,
  output logic        MEM_ERR
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    ERROR
  } state_t;

  localparam logic [3:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t state, state_d;
  logic [3:0] cnt, cnt_d;

  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        sel_q;
  logic              wr_q;

  logic [31:0] mem [2**ADDR_W];

  logic              req;
  logic              bad;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [ADDR_W-1:0] idx;
  logic              unused_addr;

  // upper address bits alias by design
  assign unused_addr = ^ADDR[31:ADDR_W+2];
  assign idx = addr_q[ADDR_W+1:2];
  assign req = MEM_OE | MEM_WS;

  // reads never fault; only misaligned or illegal-size stores do
  always_comb begin
    bad = MEM_WS & (
      (RAM_SEL == 2'b11) |
      ((RAM_SEL == 2'b00) & (ADDR[1:0] != 2'b00)) |
      ((RAM_SEL == 2'b01) & ADDR[0]));
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (bad) begin
            state_d = ERROR;
          end else if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = ACCESS;
        else             cnt_d   = cnt - 4'd1;
      end
      ACCESS:  state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    wlane = wdata_q;
    unique case (1'b1)
      sel_q == 2'b00: be = 4'b1111;
      sel_q == 2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      sel_q == 2'b10: begin
        be    = 4'b0001 << addr_q[1:0];
        wlane = {4{wdata_q[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= 2'b00;
      wr_q    <= 1'b0;
      RDATA   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == IDLE && req) begin
        addr_q  <= ADDR[ADDR_W+1:0];
        wdata_q <= WDATA;
        sel_q   <= RAM_SEL;
        wr_q    <= MEM_WS;
      end
      if (state == ACCESS && !wr_q)
        RDATA <= mem[idx];
    end
  end

  // contents survive reset; a reset before ACCESS leaves state != ACCESS
  always_ff @(posedge CLK) begin
    if (state == ACCESS && wr_q) begin
      for (int n = 0; n < 4; n++) begin
        if (be[n]) mem[idx][8*n +: 8] <= wlane[8*n +: 8];
      end
    end
  end

  assign MEM_READY = (state == ACCESS);
  assign MEM_ERR   = (state == ERROR);
  assign MEM_BUSY  = (state != IDLE);

endmodule
